// File: rtl/uart_pkg.sv
// uart_pkg: shared types and limits for the UART receiver slice.
// Holds the state encoding, parameter limits, parity-type codes, majority helper.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_DONE   = 3'd5
  } rx_state_e;

  localparam int DATA_W_MIN  = 5;
  localparam int DATA_W_MAX  = 9;
  localparam int PRESC_W_MIN = 6;
  localparam int PRESC_MIN   = 8;
  localparam int PRESC_MAX   = 62;

  // Wide enough for start + 9 data + parity + 2 stop bit indices.
  localparam int BIT_CNT_W = 4;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  function automatic logic maj3(
    input logic a,
    input logic b,
    input logic c
  );
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: per-bit edge counter, bit-end wrap and sample strobe.
// Ports: CLK/RST, rx_i line, presc_i ratio, start_i (load), en_i (count);
// wrap_o bit end, strobe_o sample point, bit_o sampled value.
// UART_RX_MAJORITY_EN: 3-sample majority vote, strobe moves to Prescale/2.
module uart_rx_sampler #(
  parameter int PRESC_W = 6
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               rx_i,
  input  logic [PRESC_W-1:0] presc_i,
  input  logic               start_i,
  input  logic               en_i,
  output logic               wrap_o,
  output logic               strobe_o,
  output logic               bit_o
);
  import uart_pkg::*;

  logic [PRESC_W-1:0] cnt_q, cnt_d;
  logic [PRESC_W-1:0] top;
  logic [PRESC_W-1:0] half;

  assign top  = presc_i - PRESC_W'(1);
  assign half = presc_i >> 1;

  // The start-detect cycle is edge 0, so the first counted cycle is 1.
  always_comb begin
    cnt_d = cnt_q;
    if (start_i) begin
      cnt_d = PRESC_W'(1);
    end else if (en_i) begin
      cnt_d = (cnt_q == top) ? '0 : cnt_q + PRESC_W'(1);
    end else begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign wrap_o = en_i && (cnt_q == top);

`ifdef UART_RX_MAJORITY_EN
  logic s0_q;
  logic s1_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      s0_q <= 1'b1;
      s1_q <= 1'b1;
    end else begin
      if (en_i && cnt_q == half - PRESC_W'(2)) begin
        s0_q <= rx_i;
      end
      if (en_i && cnt_q == half - PRESC_W'(1)) begin
        s1_q <= rx_i;
      end
    end
  end

  assign strobe_o = en_i && (cnt_q == half);
  assign bit_o    = maj3(s0_q, s1_q, rx_i);
`else
  assign strobe_o = en_i && (cnt_q == half - PRESC_W'(1));
  assign bit_o    = rx_i;
`endif

endmodule

// File: rtl/uart_rx_core.sv
// uart_rx_core: oversampling UART receiver (FSM, bit count, shift reg, checks).
// Ports: CLK, RST (async low), RX_IN, Prescale, PAR_EN, PAR_TYP, STOP2 in;
// P_DATA, data_valid, par_err, stp_err, busy out.
// UART_RX_MAJORITY_EN: majority-vote sampling inside uart_rx_sampler.
module uart_rx_core #(
  parameter int DATA_W  = 8,
  parameter int PRESC_W = 6
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               RX_IN,
  input  logic [PRESC_W-1:0] Prescale,
  input  logic               PAR_EN,
  input  logic               PAR_TYP,
  input  logic               STOP2,
  output logic [DATA_W-1:0]  P_DATA,
  output logic               data_valid,
  output logic               par_err,
  output logic               stp_err,
  output logic               busy
);
  import uart_pkg::*;

  localparam logic [BIT_CNT_W-1:0] DW = BIT_CNT_W'(DATA_W);

  rx_state_e state_q, state_d;

  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]    shreg_q, shreg_d;
  logic [DATA_W-1:0]    pdata_q, pdata_d;
  logic                 dv_q, dv_d;
  logic                 pe_q, pe_d;
  logic                 se_q, se_d;
  logic                 par_flag_q, par_flag_d;
  logic                 stp_flag_q, stp_flag_d;

  logic [PRESC_W-1:0]   presc_q;
  logic                 par_en_q;
  logic                 par_typ_q;
  logic                 stop2_q;

  logic                 start_go;
  logic                 cnt_en;
  logic                 wrap;
  logic                 strobe;
  logic                 smp_bit;
  logic [BIT_CNT_W-1:0] last_stop;

  // A new frame may begin from IDLE or straight out of DONE.
  assign start_go = ((state_q == ST_IDLE) || (state_q == ST_DONE))
                    && !RX_IN;

  assign cnt_en = (state_q == ST_START) || (state_q == ST_DATA)
               || (state_q == ST_PARITY) || (state_q == ST_STOP);

  assign last_stop = DW + BIT_CNT_W'(par_en_q) + BIT_CNT_W'(1)
                   + BIT_CNT_W'(stop2_q);

  uart_rx_sampler #(
    .PRESC_W (PRESC_W)
  ) u_sampler (
    .CLK      (CLK),
    .RST      (RST),
    .rx_i     (RX_IN),
    .presc_i  (presc_q),
    .start_i  (start_go),
    .en_i     (cnt_en),
    .wrap_o   (wrap),
    .strobe_o (strobe),
    .bit_o    (smp_bit)
  );

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    pdata_d    = pdata_q;
    par_flag_d = par_flag_q;
    stp_flag_d = stp_flag_q;
    dv_d       = 1'b0;
    pe_d       = 1'b0;
    se_d       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!RX_IN) begin
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (strobe && smp_bit) begin
          state_d = ST_IDLE;
        end else if (wrap) begin
          state_d   = ST_DATA;
          bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
        end
      end
      ST_DATA: begin
        // Bit index is bit_cnt - 1 since the start bit is index 0.
        if (strobe) begin
          for (int i = 0; i < DATA_W; i++) begin
            if (bit_cnt_q == BIT_CNT_W'(i + 1)) begin
              shreg_d[i] = smp_bit;
            end
          end
        end
        if (wrap) begin
          bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
          if (bit_cnt_q == DW) begin
            state_d = par_en_q ? ST_PARITY : ST_STOP;
          end
        end
      end
      ST_PARITY: begin
        if (strobe) begin
          par_flag_d = smp_bit ^ (^shreg_q) ^ par_typ_q;
        end
        if (wrap) begin
          bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
          state_d   = ST_STOP;
        end
      end
      ST_STOP: begin
        if (strobe && !smp_bit) begin
          stp_flag_d = 1'b1;
        end
        if (wrap) begin
          bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
          if (bit_cnt_q == last_stop) begin
            state_d = ST_DONE;
            dv_d    = !par_flag_q && !stp_flag_q;
            pe_d    = par_flag_q;
            se_d    = stp_flag_q;
            if (!par_flag_q && !stp_flag_q) begin
              pdata_d = shreg_q;
            end
          end
        end
      end
      ST_DONE: begin
        state_d = RX_IN ? ST_IDLE : ST_START;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (start_go) begin
      bit_cnt_d  = '0;
      shreg_d    = '0;
      par_flag_d = 1'b0;
      stp_flag_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      pdata_q    <= '0;
      dv_q       <= 1'b0;
      pe_q       <= 1'b0;
      se_q       <= 1'b0;
      par_flag_q <= 1'b0;
      stp_flag_q <= 1'b0;
      presc_q    <= PRESC_W'(PRESC_MIN);
      par_en_q   <= 1'b0;
      par_typ_q  <= PAR_EVEN;
      stop2_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      pdata_q    <= pdata_d;
      dv_q       <= dv_d;
      pe_q       <= pe_d;
      se_q       <= se_d;
      par_flag_q <= par_flag_d;
      stp_flag_q <= stp_flag_d;
      // Frame format is frozen for the whole frame at start detect.
      if (start_go) begin
        presc_q   <= Prescale;
        par_en_q  <= PAR_EN;
        par_typ_q <= PAR_TYP;
        stop2_q   <= STOP2;
      end
    end
  end

  assign P_DATA     = pdata_q;
  assign data_valid = dv_q;
  assign par_err    = pe_q;
  assign stp_err    = se_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: directed self-checking bench for uart_rx_core.
// Expected values hand-derived; honours UART_RX_MAJORITY_EN for the spike case.
module tb_uart_rx_core;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       RX_IN = 1'b1;
  logic [5:0] Prescale = 6'd8;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic       STOP2 = 1'b0;
  logic [7:0] P_DATA;
  logic       data_valid;
  logic       par_err;
  logic       stp_err;
  logic       busy;

  int checks = 0;
  int failures = 0;
  int dv_cnt = 0;
  int pe_cnt = 0;
  int se_cnt = 0;

  logic [15:0] fb;
  int          fn;
  logic [7:0]  spike_exp;

  always #5 CLK = ~CLK;

  uart_rx_core #(
    .DATA_W  (8),
    .PRESC_W (6)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .RX_IN      (RX_IN),
    .Prescale   (Prescale),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .STOP2      (STOP2),
    .P_DATA     (P_DATA),
    .data_valid (data_valid),
    .par_err    (par_err),
    .stp_err    (stp_err),
    .busy       (busy)
  );

  always @(negedge CLK) begin
    dv_cnt += int'(data_valid);
    pe_cnt += int'(par_err);
    se_cnt += int'(stp_err);
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // bits[0] first on the line; all bits of a frame, start to last stop.
  function automatic logic [15:0] mkframe(
    input logic [7:0] d, input logic pen, input logic ptyp,
    input logic s2, input logic flip_par, input logic s2_low,
    output int n);
    logic [15:0] b;
    int k;
    b = '0;
    k = 0;
    b[k] = 1'b0; k++;
    for (int i = 0; i < 8; i++) begin
      b[k] = d[i]; k++;
    end
    if (pen) begin
      b[k] = (^d) ^ ptyp ^ flip_par; k++;
    end
    b[k] = 1'b1; k++;
    if (s2) begin
      b[k] = ~s2_low; k++;
    end
    n = k;
    return b;
  endfunction

  // Entered #1 after a posedge (offset 0); leaves #1 into offset n*p.
  task automatic send_bits(input logic [15:0] bits, input int n,
                           input int p);
    for (int i = 0; i < n; i++) begin
      RX_IN = bits[i];
      repeat (p) @(posedge CLK);
      #1;
    end
    RX_IN = 1'b1;
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_pdata", 32'(P_DATA), 32'h00);
    chk("rst_dv", 32'(data_valid), 32'h0);
    chk("rst_pe", 32'(par_err), 32'h0);
    chk("rst_se", 32'(stp_err), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    RST = 1'b1;
    repeat (4) tick();
    chk("idle_busy", 32'(busy), 32'h0);

    // 0xA5, even parity, prescale 8: DONE at offset 88
    Prescale = 6'd8; PAR_EN = 1'b1; PAR_TYP = 1'b0; STOP2 = 1'b0;
    fb = mkframe(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, fn);
    chk("a_len", 32'(fn), 32'd11);
    send_bits(fb, fn, 8);
    chk("a_dv", 32'(data_valid), 32'h1);
    chk("a_pe", 32'(par_err), 32'h0);
    chk("a_se", 32'(stp_err), 32'h0);
    chk("a_pdata", 32'(P_DATA), 32'hA5);
    chk("a_busy_done", 32'(busy), 32'h1);
    tick();
    chk("a_dv_off", 32'(data_valid), 32'h0);
    chk("a_busy_off", 32'(busy), 32'h0);
    chk("a_dv_cnt", 32'(dv_cnt), 32'd1);

    // Bad parity on 0x3C; config changed mid-frame must be ignored
    fb = mkframe(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, fn);
    send_bits(fb, 2, 8);
    PAR_EN = 1'b0; Prescale = 6'd16; PAR_TYP = 1'b1;
    send_bits(fb >> 2, fn - 2, 8);
    chk("b_pe", 32'(par_err), 32'h1);
    chk("b_dv", 32'(data_valid), 32'h0);
    chk("b_se", 32'(stp_err), 32'h0);
    chk("b_pdata", 32'(P_DATA), 32'hA5);
    tick();
    chk("b_pe_off", 32'(par_err), 32'h0);
    chk("b_pe_cnt", 32'(pe_cnt), 32'd1);
    chk("b_dv_cnt", 32'(dv_cnt), 32'd1);

    // No parity, two stops, prescale 16, second stop low: offset 176
    Prescale = 6'd16; PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b1;
    fb = mkframe(8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, fn);
    chk("c_len", 32'(fn), 32'd11);
    send_bits(fb, fn, 16);
    chk("c_se", 32'(stp_err), 32'h1);
    chk("c_dv", 32'(data_valid), 32'h0);
    chk("c_pe", 32'(par_err), 32'h0);
    chk("c_pdata", 32'(P_DATA), 32'hA5);
    tick();
    chk("c_se_off", 32'(stp_err), 32'h0);
    chk("c_se_cnt", 32'(se_cnt), 32'd1);

    // Start glitch: low for 2 cycles, prescale 8
    Prescale = 6'd8; STOP2 = 1'b0;
    RX_IN = 1'b0;
    tick();
    chk("d_busy_start", 32'(busy), 32'h1);
    tick();
    RX_IN = 1'b1;
    repeat (4) tick();
    chk("d_busy_idle", 32'(busy), 32'h0);
    repeat (10) tick();
    chk("d_busy_late", 32'(busy), 32'h0);
    chk("d_dv_cnt", 32'(dv_cnt), 32'd1);
    chk("d_pe_cnt", 32'(pe_cnt), 32'd1);
    chk("d_se_cnt", 32'(se_cnt), 32'd1);

    // Back-to-back 0x11 / 0xEE, prescale 8, no parity
    fb = mkframe(8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, fn);
    chk("e_len", 32'(fn), 32'd10);
    send_bits(fb, fn, 8);
    chk("e_dv1", 32'(data_valid), 32'h1);
    chk("e_pdata1", 32'(P_DATA), 32'h11);
    fb = mkframe(8'hEE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, fn);
    send_bits(fb, fn, 8);
    chk("e_dv2", 32'(data_valid), 32'h1);
    chk("e_pdata2", 32'(P_DATA), 32'hEE);
    tick();
    chk("e_dv_cnt", 32'(dv_cnt), 32'd3);
    chk("e_busy", 32'(busy), 32'h0);

    // 0xFF with a one-cycle low spike at each data bit midpoint
`ifdef UART_RX_MAJORITY_EN
    spike_exp = 8'hFF;
`else
    spike_exp = 8'h00;
`endif
    RX_IN = 1'b0;
    repeat (8) tick();
    for (int i = 0; i < 8; i++) begin
      RX_IN = 1'b1;
      repeat (3) tick();
      RX_IN = 1'b0;
      tick();
      RX_IN = 1'b1;
      repeat (4) tick();
    end
    repeat (8) tick();
    chk("f_dv", 32'(data_valid), 32'h1);
    chk("f_pdata", 32'(P_DATA), 32'(spike_exp));
    tick();
    chk("f_dv_cnt", 32'(dv_cnt), 32'd4);

    // Reset at offset 40 of a 0xFF frame
    RX_IN = 1'b0;
    repeat (8) tick();
    RX_IN = 1'b1;
    repeat (32) tick();
    RST = 1'b0;
    #1;
    chk("g_pdata", 32'(P_DATA), 32'h00);
    chk("g_dv", 32'(data_valid), 32'h0);
    chk("g_pe", 32'(par_err), 32'h0);
    chk("g_se", 32'(stp_err), 32'h0);
    chk("g_busy", 32'(busy), 32'h0);
    tick();
    RST = 1'b1;
    repeat (100) tick();
    chk("g_busy_after", 32'(busy), 32'h0);
    chk("g_dv_cnt", 32'(dv_cnt), 32'd4);
    chk("g_pe_cnt", 32'(pe_cnt), 32'd1);
    chk("g_se_cnt", 32'(se_cnt), 32'd1);

    // Odd parity, prescale 10, 0x5A: DONE at offset 110
    Prescale = 6'd10; PAR_EN = 1'b1; PAR_TYP = 1'b1;
    fb = mkframe(8'h5A, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, fn);
    send_bits(fb, fn, 10);
    chk("h_dv", 32'(data_valid), 32'h1);
    chk("h_pe", 32'(par_err), 32'h0);
    chk("h_pdata", 32'(P_DATA), 32'h5A);
    tick();
    chk("h_dv_cnt", 32'(dv_cnt), 32'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
